vx_div_sequencer: RTL and testbench

- Issue/retire stage wrapped around the pipelined unsigned divider VX_divide; instantiates it with WIDTHN=WIDTHD=WIDTHQ=WIDTHR=WIDTH.
- Accepts RV32M DIV/DIVU/REM/REMU requests on a valid/ready handshake and feeds absolute-value operands to the divider.
- Carries sign, special-case and tag sideband through a shift pipeline of matching depth, then applies sign correction and special results on exit.
- Sits between the ALU dispatch and the writeback arbiter.

---
 rtl/vx_div_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_vx_div_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_div_sequencer.sv
// rtl/vx_div_sequencer.sv - signed/unsigned RV32M divide issue/retire around a pipelined divider
//
// VX_divide: unsigned divider with PIPELINE register stages and a clock enable.
//   clk, aclr, clken         clock, async active-high reset, stage enable
//   numer, denom             unsigned operands
//   quotient, remainder      results, PIPELINE enabled edges after the operands
//
// vx_div_sequencer: DIV/DIVU/REM/REMU front end for VX_divide.
//   clock, aclr                                    clock, async active-high reset
//   in_valid/in_ready/in_op/in_numer/in_denom/in_tag   request handshake
//   out_valid/out_ready/out_result/out_tag             response handshake

module VX_divide #(
    parameter int WIDTHN   = 32,
    parameter int WIDTHD   = 32,
    parameter int WIDTHQ   = 32,
    parameter int WIDTHR   = 32,
    parameter int PIPELINE = 4
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              clken,
    input  logic [WIDTHN-1:0] numer,
    input  logic [WIDTHD-1:0] denom,
    output logic [WIDTHQ-1:0] quotient,
    output logic [WIDTHR-1:0] remainder
);
    logic [WIDTHQ-1:0] q_c;
    logic [WIDTHR-1:0] r_c;
    logic [WIDTHQ-1:0] q_d [PIPELINE];
    logic [WIDTHQ-1:0] q_q [PIPELINE];
    logic [WIDTHR-1:0] r_d [PIPELINE];
    logic [WIDTHR-1:0] r_q [PIPELINE];

    // Divide-by-zero is defined here so bubbles never carry X.
    always_comb begin
        q_c = '1;
        r_c = WIDTHR'(numer);
        if (denom != '0) begin
            q_c = WIDTHQ'(numer / denom);
            r_c = WIDTHR'(numer % denom);
        end
    end

    always_comb begin
        for (int i = 0; i < PIPELINE; i++) begin
            q_d[i] = q_q[i];
            r_d[i] = r_q[i];
        end
        if (clken) begin
            q_d[0] = q_c;
            r_d[0] = r_c;
            for (int i = 1; i < PIPELINE; i++) begin
                q_d[i] = q_q[i-1];
                r_d[i] = r_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < PIPELINE; i++) begin
                q_q[i] <= '0;
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPELINE; i++) begin
                q_q[i] <= q_d[i];
                r_q[i] <= r_d[i];
            end
        end
    end

    assign quotient  = q_q[PIPELINE-1];
    assign remainder = r_q[PIPELINE-1];
endmodule

module vx_div_sequencer #(
    parameter int WIDTH    = 32,
    parameter int TAGW     = 8,
    parameter int PIPELINE = 4
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_numer,
    input  logic [WIDTH-1:0] in_denom,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAGW-1:0]  out_tag
);
    localparam int LAST = PIPELINE - 1;
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic             stall;
    logic             is_signed, is_rem, neg_n, neg_d, den_zero, ovf, special;
    logic [WIDTH-1:0] abs_n, abs_d, div_denom, spec_val;
    logic [WIDTH-1:0] div_q, div_r;

    logic [PIPELINE-1:0] vld_d, vld_q, negn_d, negn_q, negd_d, negd_q, spc_d, spc_q;
    logic [TAGW-1:0]     tag_d  [PIPELINE];
    logic [TAGW-1:0]     tag_q  [PIPELINE];
    logic [1:0]          op_d   [PIPELINE];
    logic [1:0]          op_q   [PIPELINE];
    logic [WIDTH-1:0]    sval_d [PIPELINE];
    logic [WIDTH-1:0]    sval_q [PIPELINE];

    assign out_valid = vld_q[LAST];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    // op[0]=1 selects the unsigned variants, op[1]=1 selects remainder.
    always_comb begin
        is_signed = !in_op[0];
        is_rem    = in_op[1];
        neg_n     = is_signed && in_numer[WIDTH-1];
        neg_d     = is_signed && in_denom[WIDTH-1];
        abs_n     = neg_n ? -in_numer : in_numer;
        abs_d     = neg_d ? -in_denom : in_denom;
        den_zero  = (in_denom == '0);
        ovf       = is_signed && (in_numer == MIN_INT) && (in_denom == '1);
        special   = den_zero || ovf;
        if (den_zero) begin
            spec_val = is_rem ? in_numer : '1;
        end else begin
            spec_val = is_rem ? '0 : MIN_INT;
        end
        // Specials bypass the divider; feed it a harmless divisor.
        div_denom = special ? WIDTH'(1) : abs_d;
    end

    VX_divide #(
        .WIDTHN   (WIDTH),
        .WIDTHD   (WIDTH),
        .WIDTHQ   (WIDTH),
        .WIDTHR   (WIDTH),
        .PIPELINE (PIPELINE)
    ) u_divide (
        .clk       (clock),
        .aclr      (aclr),
        .clken     (!stall),
        .numer     (abs_n),
        .denom     (div_denom),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Sideband shift pipe; freezes as a whole with the divider.
    always_comb begin
        vld_d  = vld_q;
        negn_d = negn_q;
        negd_d = negd_q;
        spc_d  = spc_q;
        for (int i = 0; i < PIPELINE; i++) begin
            tag_d[i]  = tag_q[i];
            op_d[i]   = op_q[i];
            sval_d[i] = sval_q[i];
        end
        if (!stall) begin
            vld_d[0]  = in_valid;
            negn_d[0] = neg_n;
            negd_d[0] = neg_d;
            spc_d[0]  = special;
            tag_d[0]  = in_tag;
            op_d[0]   = in_op;
            sval_d[0] = spec_val;
            for (int i = 1; i < PIPELINE; i++) begin
                vld_d[i]  = vld_q[i-1];
                negn_d[i] = negn_q[i-1];
                negd_d[i] = negd_q[i-1];
                spc_d[i]  = spc_q[i-1];
                tag_d[i]  = tag_q[i-1];
                op_d[i]   = op_q[i-1];
                sval_d[i] = sval_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            vld_q  <= '0;
            negn_q <= '0;
            negd_q <= '0;
            spc_q  <= '0;
            for (int i = 0; i < PIPELINE; i++) begin
                tag_q[i]  <= '0;
                op_q[i]   <= '0;
                sval_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            negn_q <= negn_d;
            negd_q <= negd_d;
            spc_q  <= spc_d;
            for (int i = 0; i < PIPELINE; i++) begin
                tag_q[i]  <= tag_d[i];
                op_q[i]   <= op_d[i];
                sval_q[i] <= sval_d[i];
            end
        end
    end

    always_comb begin
        out_result = '0;
        out_tag    = '0;
        if (vld_q[LAST]) begin
            out_tag = tag_q[LAST];
            if (spc_q[LAST]) begin
                out_result = sval_q[LAST];
            end else if (op_q[LAST] == 2'b00) begin
                out_result = (negn_q[LAST] ^ negd_q[LAST]) ? -div_q : div_q;
            end else if (op_q[LAST] == 2'b10) begin
                out_result = negn_q[LAST] ? -div_r : div_r;
            end else if (op_q[LAST] == 2'b01) begin
                out_result = div_q;
            end else begin
                out_result = div_r;
            end
        end
    end
endmodule

// File: tb/tb_vx_div_sequencer.sv
// tb/tb_vx_div_sequencer.sv - scoreboard bench for vx_div_sequencer
module tb_vx_div_sequencer;
    localparam int P = 4;
    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    logic        clock = 1'b0;
    logic        aclr  = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [1:0]  in_op = '0;
    logic [31:0] in_numer = '0, in_denom = '0, out_result;
    logic [7:0]  in_tag = '0, out_tag;

    logic        x_valid = 1'b0, x_rdy = 1'b1;
    logic [1:0]  x_op = '0;
    logic [31:0] x_numer = '0, x_denom = '0;
    logic [7:0]  x_tag = '0;
    logic        p1_ready, p1_valid, p8_ready, p8_valid;
    logic [31:0] p1_result, p8_result;
    logic [7:0]  p1_tag, p8_tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] res;
        logic [7:0]  tag;
        int          edge_no;
        int          stalls;
    } exp_t;
    exp_t sb[$];

    logic [31:0] exp_res = '0;
    int edges  = 0;
    int stalls = 0;

    always #5 clock = ~clock;

    vx_div_sequencer #(.WIDTH(32), .TAGW(8), .PIPELINE(P)) dut (
        .clock(clock), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_numer(in_numer), .in_denom(in_denom), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag));

    vx_div_sequencer #(.WIDTH(32), .TAGW(8), .PIPELINE(1)) dut_p1 (
        .clock(clock), .aclr(aclr), .in_valid(x_valid), .in_ready(p1_ready),
        .in_op(x_op), .in_numer(x_numer), .in_denom(x_denom), .in_tag(x_tag),
        .out_valid(p1_valid), .out_ready(x_rdy), .out_result(p1_result), .out_tag(p1_tag));

    vx_div_sequencer #(.WIDTH(32), .TAGW(8), .PIPELINE(8)) dut_p8 (
        .clock(clock), .aclr(aclr), .in_valid(x_valid), .in_ready(p8_ready),
        .in_op(x_op), .in_numer(x_numer), .in_denom(x_denom), .in_tag(x_tag),
        .out_valid(p8_valid), .out_ready(x_rdy), .out_result(p8_result), .out_tag(p8_tag));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Acceptance recorder: pushes the expected response at the accepting edge.
    always @(posedge clock) begin
        if (!aclr) begin
            edges++;
            if (out_valid && !out_ready) stalls++;
            if (in_valid && in_ready) sb.push_back('{exp_res, in_tag, edges, stalls});
        end
    end

    // Monitor: compares results against the scoreboard and checks hold/stall.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic [7:0]  prev_tag;
    always @(negedge clock) begin
        if (!aclr) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_result", out_result, prev_res);
                chk("hold_tag", 32'(out_tag), 32'(prev_tag));
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
            prev_tag   = out_tag;
            if (out_valid && !out_ready) chk("in_ready_stall", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", out_result, e.res);
                    chk("tag", 32'(out_tag), 32'(e.tag));
                    chk("latency_edges", 32'(edges - e.edge_no),
                        32'(P - 1 + (stalls - e.stalls)));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] n, input logic [31:0] d,
                         input logic [7:0] tag, input logic [31:0] exp);
        bit ok;
        int guard;
        in_valid = 1'b1; in_op = op; in_numer = n; in_denom = d; in_tag = tag; exp_res = exp;
        guard = 0;
        do begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            guard++;
        end while (!ok && guard < 100);
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: got in_ready=0, expected acceptance within 100 cycles");
        end
        #1;
    endtask

    task automatic drain();
        int guard;
        in_valid = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(posedge clock);
            guard++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
        #1;
    endtask

    task automatic depth_check(input logic [1:0] op, input logic [31:0] exp);
        @(posedge clock); #1;
        x_valid = 1'b1; x_op = op; x_numer = 32'd100; x_denom = 32'd7; x_tag = 8'h5A;
        @(posedge clock); #1;
        x_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            chk($sformatf("p1_valid_n%0d", n), 32'(p1_valid), 32'(n == 0));
            chk($sformatf("p8_valid_n%0d", n), 32'(p8_valid), 32'(n == 7));
            if (n == 0) chk("p1_result", p1_result, exp);
            if (n == 7) begin
                chk("p8_result", p8_result, exp);
                chk("p8_tag", 32'(p8_tag), 32'h5A);
            end
        end
    endtask

    localparam logic [31:0] STREAM_Q [8] = '{32'd0, 32'd3, 32'd6, 32'd10,
                                             32'd13, 32'd16, 32'd20, 32'd23};

    initial begin
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_p8_valid", 32'(p8_valid), 32'd0);
        @(posedge clock); #3;
        aclr = 1'b0;
        @(posedge clock); #1;

        issue(DIVU, 32'd56, 32'd11, 8'h03, 32'd5);
        in_valid = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        issue(REMU, 32'd56, 32'd11, 8'h04, 32'd1);
        issue(DIV,  32'hFFFFFFC8, 32'd11, 8'h05, 32'hFFFFFFFB);
        issue(REM,  32'hFFFFFFC8, 32'd11, 8'h06, 32'hFFFFFFFF);
        issue(DIV,  32'd56, 32'hFFFFFFF5, 8'h07, 32'hFFFFFFFB);
        issue(REM,  32'd56, 32'hFFFFFFF5, 8'h08, 32'd1);
        issue(DIV,  32'd7, 32'd0, 8'h09, 32'hFFFFFFFF);
        issue(REMU, 32'd7, 32'd0, 8'h0A, 32'd7);
        issue(DIV,  32'h80000000, 32'hFFFFFFFF, 8'h0B, 32'h80000000);
        issue(REM,  32'h80000000, 32'hFFFFFFFF, 8'h0C, 32'd0);
        issue(DIVU, 32'hFFFFFFFF, 32'd16, 8'h0D, 32'h0FFFFFFF);
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue(DIVU, 32'(i * 10), 32'd3, 8'(8'h10 + i), STREAM_Q[i]);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        issue(DIVU, 32'd90, 32'd9, 8'h21, 32'd10);
        issue(DIVU, 32'd91, 32'd9, 8'h22, 32'd10);
        issue(REMU, 32'd91, 32'd9, 8'h23, 32'd1);
        in_valid = 1'b0;
        @(posedge clock); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 aclr = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        #10 aclr = 1'b0;
        for (int n = 0; n < P + 2; n++) begin
            @(negedge clock);
            chk($sformatf("post_rst_valid_%0d", n), 32'(out_valid), 32'd0);
            chk($sformatf("post_rst_in_ready_%0d", n), 32'(in_ready), 32'd1);
        end

        depth_check(DIVU, 32'd14);
        depth_check(REMU, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
